// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the FSM state encoding, the BCD digit type and the digit clamp.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle between panel logic and the countdown timer.
// Master drives the control strobes; slave (the timer) drives count and status.
interface bcd_down_timer_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;
  logic                  zero;

  modport master (
    output load, load_val, start, pause, tick,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, pause, tick,
    output count, busy, done, zero
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: load, or decrement with 0 -> 9 wrap.
// Latency: digit updates one cycle after load/dec_in; no backpressure, strobes always taken.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       dec_in,
  output bcd_digit_t digit,
  output logic       is_zero,
  output logic       borrow_out
);

  assign is_zero    = (digit == 4'd0);
  assign borrow_out = dec_in & is_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec_in) begin
      digit <= is_zero ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer; BCD_DOWN_TIMER_AUTO_RELOAD_EN makes it periodic.
// Latency: count/busy/done update one cycle after the qualifying input; no backpressure.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_down_timer_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  state_t              state;
  logic                busy_q;
  logic                done_q;
  logic [W-1:0]        preset;
  logic [W-1:0]        count_int;
  logic [W-1:0]        load_clamped;
  logic [W-1:0]        digit_src;
  logic [DIGITS-1:0]   dig_zero;
  logic [DIGITS-1:0]   dec;
  logic                borrow_unused;
  logic                last_step;
  logic                reload;
  logic                dig_load;

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
    end
  end

  // The tick that takes count from 0..01 to 0 ends (or, periodic, restarts) the run.
  assign last_step = (state == ST_RUN) && !bus.load && !bus.pause && bus.tick &&
                     (count_int == W'(1));

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  assign reload = last_step && (preset != '0);
`else
  assign reload = 1'b0;
`endif

  assign dig_load  = bus.load | reload;
  assign digit_src = bus.load ? load_clamped : preset;
  assign dec[0]    = (state == ST_RUN) && bus.tick && !bus.load && !bus.pause && !reload;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i < DIGITS - 1) begin : g_mid
      bcd_down_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .load       (dig_load),
        .load_digit (digit_src[4*i +: 4]),
        .dec_in     (dec[i]),
        .digit      (count_int[4*i +: 4]),
        .is_zero    (dig_zero[i]),
        .borrow_out (dec[i+1])
      );
    end else begin : g_top
      bcd_down_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .load       (dig_load),
        .load_digit (digit_src[4*i +: 4]),
        .dec_in     (dec[i]),
        .digit      (count_int[4*i +: 4]),
        .is_zero    (dig_zero[i]),
        .borrow_out (borrow_unused)
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      preset <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        preset <= load_clamped;
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (&dig_zero) begin
                state <= ST_EXPIRED;
              end else begin
                state  <= ST_RUN;
                busy_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (bus.pause) begin
              state  <= ST_PAUSED;
              busy_q <= 1'b0;
            end else if (last_step) begin
              done_q <= 1'b1;
              if (!reload) begin
                state  <= ST_EXPIRED;
                busy_q <= 1'b0;
              end
            end
          end
          ST_PAUSED: begin
            if (bus.start) begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count = count_int;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = &dig_zero;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter/countdown timer; the decrementing counterpart of the team's mod-10 up counter.
- Loads a BCD preset, counts down one LSD step per `tick` while running, and flags completion at 0.
- Sits between front-panel/control logic and the seven-segment display path; display decoders consume `count` directly.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; `count` width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; capture `load_val` as the new preset and count.
- load_val  input  4*DIGITS  BCD preset; digit i in bits [4i+3:4i].
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting; count holds.
- tick  input  1  count-enable strobe, e.g. from a prescaler; one decrement per high cycle while RUN.
- count  output  4*DIGITS  current BCD value.
- busy  output  1  high in RUN state.
- done  output  1  one-cycle pulse when count reaches 0 from RUN.
- zero  output  1  combinational: `count` == 0.

Behaviour:
- Reset (sync, rst=1 at rising edge):
  - count=0, state=IDLE, busy=0, done=0, preset register=0.
  - rst overrides all other inputs, including mid-RUN.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Priority per cycle: rst > load > pause > start > tick.
- load (any state):
  - count and preset take `load_val` next cycle; state goes to IDLE.
  - Any digit >9 is clamped to 9 at capture.
  - A coincident start is ignored.
- IDLE:
  - start with count != 0 -> RUN.
  - start with count == 0 -> EXPIRED, no done pulse.
- RUN:
  - Each cycle with tick=1: LSD decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - A digit decrements only when all lower digits are 0 and tick=1.
  - When count is 0…01 and tick=1: count becomes 0, state -> EXPIRED, done=1 for exactly that following cycle.
  - pause -> PAUSED; a tick in the same cycle is dropped.
- PAUSED: count holds; start -> RUN; tick ignored.
- EXPIRED: count holds at 0; only load or rst leave this state. start is ignored.
- busy = (state==RUN), registered alongside the state.
- Latency: count updates one cycle after the qualifying tick. done is asserted in the same cycle count first reads 0.
- No underflow: count never wraps below 0.

Optional Feature:
- Macro: BCD_DOWN_TIMER_AUTO_RELOAD_EN.
- With the macro defined, the RUN tick that would reach 0 instead:
  - reloads count from the preset register;
  - pulses done for one cycle;
  - stays in RUN (periodic timer).
  - A preset of 0 still goes to EXPIRED.
- Without the macro: single-shot behaviour as specified above.

Decomposition:
- Package `bcd_timer_pkg`:
  - state enum (IDLE/RUN/PAUSED/EXPIRED);
  - BCD_MAX = 4'd9;
  - BCD digit typedef (4-bit);
  - clamp function.
- One sub-module, `bcd_down_digit`:
  - ports: clk, rst, load, load_digit, dec_in, digit, is_zero, borrow_out;
  - borrow_out = dec_in & is_zero.
- Top-level logic:
  - instantiates DIGITS copies, chaining borrow_out -> dec_in;
  - owns the FSM, the preset register and done generation.

Test Plan:
- Reset mid-RUN with count=0x0042 -> next cycle count=0x0000, busy=0, done=0, state IDLE.
- load 0x0103, start, 4 ticks -> count 0x0102, 0x0101, 0x0100, 0x0099; borrow crosses two digits.
- load 0x0002, start, 2 ticks -> count 0x0000, done high exactly one cycle, busy=0; further ticks and start leave count=0.
- RUN at 0x0050, pause+tick same cycle -> count stays 0x0050; 3 ticks in PAUSED -> no change; start, tick -> 0x0049.
- load 0x00A7 -> count 0x0097; load+start same cycle -> IDLE, busy=0.
- AUTO_RELOAD_EN defined, preset 0x0003, start, 6 ticks -> 2,1,3(done),2,1,3(done); busy stays 1.
